// File: rtl/vdcorput_seq_driver.sv
// Request sequencer and (k, result) output FIFO in front of a van der Corput core.
// Issues one request per core ready window and streams captured results downstream.
module vdcorput_seq_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter logic [31:0] K_START    = 32'd1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              seed_load_i,
  input  logic [31:0]       seed_k_i,
  input  logic [1:0]        base_sel_in_i,
  output logic              core_start_o,
  output logic [31:0]       core_k_o,
  output logic [1:0]        core_base_sel_o,
  input  logic [31:0]       core_result_i,
  input  logic              core_done_i,
  input  logic              core_ready_i,
  output logic              out_valid_o,
  output logic [31:0]       out_data_o,
  output logic [31:0]       out_k_o,
  input  logic              out_ready_i,
  output logic [ADDR_W:0]   fifo_count_o,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | waiting for en, core ready and FIFO space; seed_load accepted here
  // ISSUE | one-cycle start pulse to the core
  // WAIT  | request in flight; core_done pushes the result and bumps k_cnt
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [31:0]       k_cnt_q, k_cnt_d;
  logic [31:0]       core_k_q, core_k_d;
  logic [1:0]        base_q, base_d;

  logic [31:0]       mem_k_q    [FIFO_DEPTH];
  logic [31:0]       mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              push, pop;

  always_comb begin
    state_d  = state_q;
    k_cnt_d  = k_cnt_q;
    core_k_d = core_k_q;
    base_d   = base_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seed_load_i) begin
          k_cnt_d = seed_k_i;
        end else if (en_i && core_ready_i && (count_q < DEPTH_C)) begin
          // FIFO slot is reserved here, so the later push can never overflow
          state_d  = S_ISSUE;
          core_k_d = k_cnt_q;
          base_d   = base_sel_in_i;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done_i) begin
          push    = 1'b1;
          k_cnt_d = k_cnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      k_cnt_q  <= K_START;
      core_k_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_cnt_q  <= k_cnt_d;
      core_k_q <= core_k_d;
      base_q   <= base_d;
    end
  end

  assign pop = (count_q != '0) && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_k_q[wr_ptr_q]    <= core_k_q;
        mem_data_q[wr_ptr_q] <= core_result_i;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign core_start_o    = (state_q == S_ISSUE);
  assign core_k_o        = core_k_q;
  assign core_base_sel_o = base_q;
  assign busy_o          = (state_q != S_IDLE);
  assign out_valid_o     = (count_q != '0);
  assign out_k_o         = mem_k_q[rd_ptr_q];
  assign out_data_o      = mem_data_q[rd_ptr_q];
  assign fifo_count_o    = count_q;

endmodule

// File: tb/tb_vdcorput_seq_driver.sv
// Bench for vdcorput_seq_driver: behavioural core stand-in, cycle scoreboard,
// vector table, directed corner sequences and a randomized run.
module tb_vdcorput_seq_driver;
  localparam int          AW      = 2;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] K_START = 32'd1;

  logic        clk = 1'b0;
  logic        rst_n, en, seed_load, out_ready;
  logic [31:0] seed_k;
  logic [1:0]  base_sel;
  logic        core_start, core_done, core_ready;
  logic [31:0] core_k, core_result, out_data, out_k;
  logic [1:0]  core_base_sel;
  logic        out_valid, busy;
  logic [AW:0] fifo_count;

  always #5 clk = ~clk;

  vdcorput_seq_driver #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .K_START(K_START)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .seed_load_i(seed_load), .seed_k_i(seed_k),
    .base_sel_in_i(base_sel), .core_start_o(core_start), .core_k_o(core_k),
    .core_base_sel_o(core_base_sel), .core_result_i(core_result), .core_done_i(core_done),
    .core_ready_i(core_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_k_o(out_k), .out_ready_i(out_ready), .fifo_count_o(fifo_count), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  function automatic void chk_near(string name, logic [31:0] act, logic [31:0] exp);
    logic [31:0] diff;
    checks++;
    diff = (act > exp) ? act - exp : exp - act;
    if (diff > 32'h100 || $isunknown(act)) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (+/-0x100)", name, act, exp);
    end
  endfunction

  // Radical inverse of k in base 2/3/7, as 16.16 fixed point
  function automatic logic [31:0] vdc(logic [31:0] k, logic [1:0] bs);
    longint unsigned kk;
    int  b;
    real r, w;
    b  = (bs == 2'd1) ? 3 : (bs == 2'd2) ? 7 : 2;
    kk = longint'(k);
    r  = 0.0;
    w  = 1.0 / real'(b);
    while (kk > 0) begin
      r  = r + real'(kk % longint'(b)) * w;
      kk = kk / longint'(b);
      w  = w / real'(b);
    end
    return 32'($rtoi(r * 65536.0));
  endfunction

  // ---------------- core stand-in ----------------
  int          lat_fixed = -1;
  logic        cm_busy;
  logic [31:0] cm_k;
  logic [1:0]  cm_b;
  int          cm_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      core_ready <= 1'b1;
      core_done  <= 1'b0;
      cm_busy    <= 1'b0;
      cm_cnt     <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_done) core_ready <= 1'b1;
      if (!cm_busy && core_start) begin
        cm_busy    <= 1'b1;
        core_ready <= 1'b0;
        cm_k       <= core_k;
        cm_b       <= core_base_sel;
        cm_cnt     <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end else if (cm_busy) begin
        if (cm_cnt == 0) begin
          core_done   <= 1'b1;
          core_result <= vdc(cm_k, cm_b);
          cm_busy     <= 1'b0;
        end else begin
          cm_cnt <= cm_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] k; logic [31:0] d; } ent_t;
  ent_t        sq[$];
  logic [31:0] m_k = K_START;
  bit          m_infl = 1'b0;
  bit          m_exp_start = 1'b0;
  logic [1:0]  m_base_prev = 2'd0;
  logic [1:0]  m_base_iss = 2'd0;
  int          starts_seen = 0;

  always @(negedge clk) begin
    bit idle_c;
    int cnt_c;
    idle_c = !core_start && !m_infl;
    cnt_c  = sq.size();
    chk("start_pred", {31'd0, core_start}, {31'd0, m_exp_start});
    chk("busy", {31'd0, busy}, {31'd0, !idle_c});
    chk("fifo_count", 32'(fifo_count), 32'(cnt_c));
    chk("out_valid", {31'd0, out_valid}, {31'd0, cnt_c != 0});
    if (core_start) begin
      chk("issue_k", core_k, m_k);
      chk("issue_base", {30'd0, core_base_sel}, {30'd0, m_base_prev});
      m_base_iss = m_base_prev;
      starts_seen++;
    end
    if (!rst_n) begin
      sq.delete();
      m_k         = K_START;
      m_infl      = 1'b0;
      m_exp_start = 1'b0;
    end else begin
      if (out_valid && out_ready && cnt_c > 0) begin
        chk("pop_k", out_k, sq[0].k);
        chk("pop_data", out_data, sq[0].d);
        void'(sq.pop_front());
      end
      if (core_done && m_infl) begin
        sq.push_back('{m_k, vdc(m_k, m_base_iss)});
        m_k    = m_k + 32'd1;
        m_infl = 1'b0;
      end
      if (core_start) m_infl = 1'b1;
      m_exp_start = idle_c && !seed_load && en && core_ready && (cnt_c < DEPTH);
      if (idle_c && seed_load) m_k = seed_k;
    end
    m_base_prev = base_sel;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    chk("wait_idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid) break;
      tick();
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic do_seed(input logic [31:0] k);
    seed_load = 1'b1;
    seed_k    = k;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic get_out(input string name, input logic [31:0] ek, input logic [31:0] ed);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        chk({name, "_k"}, out_k, ek);
        chk_near({name, "_data"}, out_data, ed);
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [1:0]  base;
    logic [31:0] exp_k;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[12];
  int   s0;
  bit   ok;

  initial begin
    vecs[0]  = '{32'd1,          2'd0, 32'd1,          32'h8000};
    vecs[1]  = '{32'd2,          2'd0, 32'd2,          32'h4000};
    vecs[2]  = '{32'd3,          2'd0, 32'd3,          32'hC000};
    vecs[3]  = '{32'd4,          2'd0, 32'd4,          32'h2000};
    vecs[4]  = '{32'd1,          2'd1, 32'd1,          32'h5555};
    vecs[5]  = '{32'd2,          2'd1, 32'd2,          32'hAAAA};
    vecs[6]  = '{32'd3,          2'd1, 32'd3,          32'h1C71};
    vecs[7]  = '{32'd4,          2'd1, 32'd4,          32'h71C7};
    vecs[8]  = '{32'd5,          2'd1, 32'd5,          32'hC71C};
    vecs[9]  = '{32'd11,         2'd2, 32'd11,         32'h9782};
    vecs[10] = '{32'hFFFF_FFFF,  2'd0, 32'hFFFF_FFFF,  32'hFFFF};
    vecs[11] = '{32'd0,          2'd0, 32'd0,          32'h0000};

    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_k = '0; base_sel = 2'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_core_k", core_k, 32'd0);
    chk("rst_base", {30'd0, core_base_sel}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // sequence from reset, base 2
    en = 1'b1; out_ready = 1'b1;
    get_out("t1_0", 32'd1, 32'h8000);
    get_out("t1_1", 32'd2, 32'h4000);
    get_out("t1_2", 32'd3, 32'hC000);
    get_out("t1_3", 32'd4, 32'h2000);

    // back-pressure fills the FIFO, then drains in order
    wait_idle(); drain(); do_seed(32'd1);
    base_sel = 2'd1; en = 1'b1; out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo_count == 3'd4) begin ok = 1'b1; break; end
      tick();
    end
    chk("t2_fill_timeout", {31'd0, ok}, 32'd1);
    s0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_start) s0++;
      tick();
    end
    chk("t2_no_start_full", 32'(s0), 32'd0);
    chk("t2_count_full", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    get_out("t2_0", 32'd1, 32'h5555);
    get_out("t2_1", 32'd2, 32'hAAAA);
    get_out("t2_2", 32'd3, 32'h1C71);
    get_out("t2_3", 32'd4, 32'h71C7);
    get_out("t2_4", 32'd5, 32'hC71C);

    // seed in IDLE with base 7
    wait_idle(); drain();
    base_sel = 2'd2; do_seed(32'd11);
    en = 1'b1; out_ready = 1'b1;
    get_out("t3", 32'd11, 32'h9782);

    // k counter wrap
    wait_idle(); drain();
    base_sel = 2'd0; do_seed(32'hFFFF_FFFF);
    en = 1'b1; out_ready = 1'b1;
    get_out("t4_0", 32'hFFFF_FFFF, 32'hFFFF);
    get_out("t4_1", 32'd0, 32'h0000);
    get_out("t4_2", 32'd1, 32'h8000);

    // vector table: one request per entry
    for (int v = 0; v < 12; v++) begin
      wait_idle(); drain();
      base_sel = vecs[v].base;
      do_seed(vecs[v].seed);
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (out_valid) begin ok = 1'b1; break; end
        tick();
      end
      en = 1'b0;
      chk("vec_timeout", {31'd0, ok}, 32'd1);
      chk("vec_k", out_k, vecs[v].exp_k);
      chk_near("vec_data", out_data, vecs[v].exp_d);
    end

    // en dropped one cycle after the start pulse
    wait_idle(); drain();
    base_sel = 2'd0; do_seed(32'd7);
    en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (core_start) begin ok = 1'b1; break; end
      tick();
    end
    chk("t5_start_timeout", {31'd0, ok}, 32'd1);
    tick();
    en = 1'b0;
    s0 = starts_seen;
    for (int i = 0; i < 30; i++) tick();
    chk("t5_no_more_start", 32'(starts_seen), 32'(s0));
    chk("t5_count", 32'(fifo_count), 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_k", out_k, 32'd7);

    // reset while a request is in flight with two entries buffered
    wait_idle(); drain();
    lat_fixed = 6;
    base_sel = 2'd0; do_seed(32'd1);
    en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo_count == 3'd2 && busy && !core_start) begin ok = 1'b1; break; end
      tick();
    end
    chk("t6_wait_timeout", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_core_start", {31'd0, core_start}, 32'd0);
    chk("t6_core_k", core_k, 32'd0);
    chk("t6_base", {30'd0, core_base_sel}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    lat_fixed = -1;
    out_ready = 1'b1;
    get_out("t6_first", K_START, 32'h8000);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      base_sel  = 2'($urandom_range(0, 2));
      seed_load = ($urandom_range(0, 25) == 0);
      seed_k    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      rst_n     = ($urandom_range(0, 700) != 0);
      tick();
    end
    rst_n = 1'b1; seed_load = 1'b0;
    wait_idle(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
